// File: rtl/axil_led_regs_if.sv
// AXI4-lite slave bus bundle for axil_led_regs: 32-bit data, 4-bit strobe,
// parameterised address width.
interface axil_led_regs_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] s_axil_awaddr;
   logic [2:0]            s_axil_awprot;
   logic                  s_axil_awvalid;
   logic                  s_axil_awready;
   logic [31:0]           s_axil_wdata;
   logic [3:0]            s_axil_wstrb;
   logic                  s_axil_wvalid;
   logic                  s_axil_wready;
   logic [1:0]            s_axil_bresp;
   logic                  s_axil_bvalid;
   logic                  s_axil_bready;
   logic [ADDR_WIDTH-1:0] s_axil_araddr;
   logic [2:0]            s_axil_arprot;
   logic                  s_axil_arvalid;
   logic                  s_axil_arready;
   logic [31:0]           s_axil_rdata;
   logic [1:0]            s_axil_rresp;
   logic                  s_axil_rvalid;
   logic                  s_axil_rready;

   modport master (
      output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      input  s_axil_awready,
      output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      input  s_axil_wready,
      input  s_axil_bresp, s_axil_bvalid,
      output s_axil_bready,
      output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      input  s_axil_arready,
      input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output s_axil_rready
   );

   modport slave (
      input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      output s_axil_awready,
      input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      output s_axil_wready,
      output s_axil_bresp, s_axil_bvalid,
      input  s_axil_bready,
      input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      output s_axil_arready,
      output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  s_axil_rready
   );
endinterface

// File: rtl/axil_led_regs.sv
// AXI4-lite LED register block with blink generator and registered LED output.
// Define AXIL_LED_REGS_TOGGLE_CNT_EN to add the phase-toggle counter at offset 0x14.
module axil_led_regs #(
   parameter int ADDR_WIDTH = 16,
   parameter int LED_COUNT  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axil_led_regs_if.slave       s_axil,
   output logic [LED_COUNT-1:0] led
);
   localparam logic [2:0]  OFS_CTRL    = 3'd0;
   localparam logic [2:0]  OFS_LED     = 3'd1;
   localparam logic [2:0]  OFS_PERIOD  = 3'd2;
   localparam logic [2:0]  OFS_ID      = 3'd3;
   localparam logic [2:0]  OFS_SCRATCH = 3'd4;
   localparam logic [31:0] ID_VALUE    = 32'h4C45_4431;
   localparam logic [31:0] LED_MASK    = 32'((64'd1 << LED_COUNT) - 64'd1);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [ADDR_WIDTH-1:0] w_awaddr;
   logic [ADDR_WIDTH-1:0] w_araddr;
   logic [2:0]            w_wr_sel;
   logic [2:0]            w_rd_sel;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic                  w_wr_period;
   logic [31:0]           w_wmask;
   logic [31:0]           w_wr_old;
   logic [31:0]           w_wr_merged;
   logic [31:0]           w_rd_data;
   logic                  w_blink_on;
   logic                  w_wrap;
   logic                  w_unused;

   logic                  r_ctrl;
   logic [31:0]           r_led_val;
   logic [31:0]           r_period;
   logic [31:0]           r_scratch;
   logic [31:0]           r_cnt;
   logic                  r_phase;
   logic [LED_COUNT-1:0]  r_led;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic                  r_rvalid;
   logic [1:0]            r_rresp;
   logic [31:0]           r_rdata;

   assign w_awaddr = s_axil.s_axil_awaddr;
   assign w_araddr = s_axil.s_axil_araddr;
   assign w_wr_sel = w_awaddr[4:2];
   assign w_rd_sel = w_araddr[4:2];
   assign w_unused = ^{s_axil.s_axil_awprot, s_axil.s_axil_arprot, w_awaddr, w_araddr};

   // Ready is combinational so the update lands on the accepting edge; gated off during reset.
   assign w_wr_en = rst_n & s_axil.s_axil_awvalid & s_axil.s_axil_wvalid & ~r_bvalid;
   assign w_rd_en = rst_n & s_axil.s_axil_arvalid & ~r_rvalid;
   assign w_wr_period = w_wr_en & (w_wr_sel == OFS_PERIOD);

   assign s_axil.s_axil_awready = w_wr_en;
   assign s_axil.s_axil_wready  = w_wr_en;
   assign s_axil.s_axil_bvalid  = r_bvalid;
   assign s_axil.s_axil_bresp   = r_bresp;
   assign s_axil.s_axil_arready = w_rd_en;
   assign s_axil.s_axil_rvalid  = r_rvalid;
   assign s_axil.s_axil_rresp   = r_rresp;
   assign s_axil.s_axil_rdata   = r_rdata;
   assign led = r_led;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wmask[gi*8 +: 8] = {8{s_axil.s_axil_wstrb[gi]}};
   end
   assign w_wr_merged = (w_wr_old & ~w_wmask) | (s_axil.s_axil_wdata & w_wmask);

   always_comb begin
      w_wr_old = 32'd0;
      w_wr_ok  = 1'b1;
      case (w_wr_sel)
         OFS_CTRL:    w_wr_old = {31'd0, r_ctrl};
         OFS_LED:     w_wr_old = r_led_val;
         OFS_PERIOD:  w_wr_old = r_period;
         OFS_ID:      w_wr_old = 32'd0;
         OFS_SCRATCH: w_wr_old = r_scratch;
`ifdef AXIL_LED_REGS_TOGGLE_CNT_EN
         3'd5:        w_wr_old = 32'd0;
`endif
         default:     w_wr_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl    <= 1'b0;
         r_led_val <= 32'd0;
         r_period  <= 32'd0;
         r_scratch <= 32'd0;
      end else if (w_wr_en) begin
         case (w_wr_sel)
            OFS_CTRL:    r_ctrl    <= w_wr_merged[0];
            OFS_LED:     r_led_val <= w_wr_merged & LED_MASK;
            OFS_PERIOD:  r_period  <= w_wr_merged;
            OFS_SCRATCH: r_scratch <= w_wr_merged;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_wr_en) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axil.s_axil_bready) begin
         r_bvalid <= 1'b0;
      end
   end

   assign w_blink_on = r_ctrl & (r_period != 32'd0);
   assign w_wrap     = (r_cnt == r_period - 32'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 32'd0;
         r_phase <= 1'b0;
         r_led   <= '0;
      end else begin
         if (w_wr_period || !w_blink_on) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b1;
         end else if (w_wrap) begin
            r_cnt   <= 32'd0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt   <= r_cnt + 32'd1;
         end
         r_led <= r_led_val[LED_COUNT-1:0] & {LED_COUNT{r_phase}};
      end
   end

`ifdef AXIL_LED_REGS_TOGGLE_CNT_EN
   localparam logic [2:0] OFS_TCNT = 3'd5;
   logic [31:0] r_toggle_cnt;
   logic        w_toggle;

   // Only count edges where the phase really flips (a PERIOD write pre-empts the wrap).
   assign w_toggle = w_blink_on & ~w_wr_period & w_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_toggle_cnt <= 32'd0;
      end else if (w_wr_en && (w_wr_sel == OFS_TCNT)) begin
         r_toggle_cnt <= 32'd0;
      end else if (w_toggle) begin
         r_toggle_cnt <= r_toggle_cnt + 32'd1;
      end
   end
`endif

   always_comb begin
      w_rd_data = 32'd0;
      w_rd_ok   = 1'b1;
      case (w_rd_sel)
         OFS_CTRL:    w_rd_data = {31'd0, r_ctrl};
         OFS_LED:     w_rd_data = r_led_val;
         OFS_PERIOD:  w_rd_data = r_period;
         OFS_ID:      w_rd_data = ID_VALUE;
         OFS_SCRATCH: w_rd_data = r_scratch;
`ifdef AXIL_LED_REGS_TOGGLE_CNT_EN
         OFS_TCNT:    w_rd_data = r_toggle_cnt;
`endif
         default:     w_rd_ok   = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= 32'd0;
      end else if (w_rd_en) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= w_rd_data;
      end else if (r_rvalid && s_axil.s_axil_rready) begin
         r_rvalid <= 1'b0;
      end
   end
endmodule

// File: doc/axil_led_regs.md
AXIL_LED_REGS -- requirements
Module: axil_led_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Parameter ADDR_WIDTH, default 16: AXI-lite address width. Data width is fixed at 32 and strobe width at 4.
REQ-003 Parameter LED_COUNT, default 8, range 1..32: number of LED outputs.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_awprot  in  3  ignored
- s_axil_awvalid  in  1  write address valid
- s_axil_awready  out  1  write address accept
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  byte enables
- s_axil_wvalid  in  1  write data valid
- s_axil_wready  out  1  write data accept
- s_axil_bresp  out  2  write response
- s_axil_bvalid  out  1  write response valid
- s_axil_bready  in  1  write response accept
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_arprot  in  3  ignored
- s_axil_arvalid  in  1  read address valid
- s_axil_arready  out  1  read address accept
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid  out  1  read data valid
- s_axil_rready  in  1  read data accept
- led  out  LED_COUNT  LED drive

Function
REQ-005 Address decode SHALL use addr[4:2] only. addr[1:0] and the upper bits are ignored.
REQ-006 Register map:
- 0x00 CTRL, RW: bit0 blink_en; other bits read 0.
- 0x04 LED_VAL, RW: bits [LED_COUNT-1:0].
- 0x08 PERIOD, RW: 32 bits.
- 0x0C ID, RO: 0x4C454431.
- 0x10 SCRATCH, RW: 32 bits.
REQ-007 Unmapped offsets SHALL return resp 2'b10 (SLVERR) and rdata 0. Writes to unmapped offsets SHALL have no effect. Writes to ID SHALL return OKAY and be ignored.
REQ-008 Write handshake:
- awready and wready SHALL pulse high together for one cycle only when awvalid && wvalid && !bvalid.
- The register update SHALL take effect on that same edge.
- bvalid SHALL rise the next cycle and hold, with bresp stable, until bready.
- A new write SHALL NOT be accepted while bvalid is high.
REQ-009 Writes SHALL update only the byte lanes whose wstrb bit is set. wstrb = 0 SHALL return OKAY and change nothing.
REQ-010 Read handshake:
- arready SHALL pulse for one cycle when arvalid && !rvalid.
- rvalid SHALL rise the next cycle with rdata/rresp, which hold stable until rready.
- A read SHALL NOT be accepted while rvalid is high.
REQ-011 When a read and a write are accepted in the same cycle to the same register, the read SHALL return the pre-write value.
REQ-012 Blink counter:
- With blink_en=1 and PERIOD≠0, a 32-bit counter increments each cycle.
- At PERIOD-1 the counter wraps to 0 and toggles phase.
- With blink_en=0 or PERIOD=0, the counter is held at 0 and phase is forced to 1.
- A write to PERIOD SHALL clear the counter and set phase to 1.
REQ-013 led SHALL be registered: led = LED_VAL & {LED_COUNT{phase}}, updated one cycle after the source change.

Reset
REQ-014 While rst_n=0, the following SHALL be 0 asynchronously:
- all registers, the counter and phase;
- led;
- awready, wready, bvalid, arready, rvalid;
- bresp, rresp, rdata.
REQ-015 Reset asserted mid-transaction SHALL drop any pending response. After reset deasserts, the first accept SHALL occur no earlier than the first rising edge.

Configuration
REQ-016 When macro AXIL_LED_REGS_TOGGLE_CNT_EN is defined:
- offset 0x14 SHALL be a RO 32-bit count of phase toggles, wrapping at 2^32-1 to 0;
- the count SHALL be cleared by reset or by any write to 0x14, and that write returns OKAY.
REQ-017 When the macro is undefined, 0x14 SHALL be unmapped per REQ-007 and no toggle counter logic SHALL exist.

Verification
REQ-018 Reset, then read 0x0C -> rdata 0x4C454431, rresp 00. Read 0x00 -> 0.
REQ-019 Write 0x04 = 0xA5 with wstrb 0xF -> bresp 00, led = 0xA5 within 2 cycles. Then write 0x10 = 0xFFFFFFFF with wstrb 0x2, read back -> 0x0000FF00.
REQ-020 Write PERIOD = 4, CTRL = 1, LED_VAL = 0xFF -> led toggles between 0xFF and 0x00 every 4 cycles. Then write CTRL = 0 -> led = 0xFF steady.
REQ-021 Hold bready=0 for 5 cycles after a write with a second write pending -> bvalid held, awready/wready stay 0. Release bready -> the second write is accepted on the next cycle.
REQ-022 Read 0x18 -> rresp 10, rdata 0. Read 0x14 -> toggle count with the macro defined, SLVERR without it.
REQ-023 Assert rst_n low while bvalid=1 and bready=0 -> bvalid drops immediately and led = 0.
